fifo_sort_engine: RTL and testbench

Downstream consumer of the AXI4-Lite write-side value FIFO. On a start pulse it drains up to `DEPTH` bytes from the FIFO and inserts each one into an ascending-ordered register buffer, one element per cycle. It then streams the sorted result out over a valid/ready interface, flagging the last element, and returns to idle.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_slot.sv | 48 ++++
 rtl/fifo_sort_engine.sv | 175 +++++++++++++++++
 tb/tb_fifo_sort_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the FIFO sort engine.
//   sort_state_e : FSM state encoding (IDLE, FILL, EMIT, DONE)
//   SORT_DATA_W  : default key width, matches the upstream FIFO data width
//   SORT_DEPTH   : default sort buffer capacity
//   SORT_CNT_W   : default width of the element count output
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } sort_state_e;

    localparam int SORT_DATA_W = 8;
    localparam int SORT_DEPTH  = 16;
    localparam int SORT_CNT_W  = 8;

endpackage

// File: rtl/sort_slot.sv
// One entry of the ascending sort buffer.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   clr               : empty the slot (start of a run)
//   load_new          : capture new_val (this slot is the insert position)
//   take_low          : capture the lower neighbour's value/occupancy (shift up)
//   new_val           : word being inserted this cycle
//   low_val, low_occ  : lower neighbour's contents
//   val, occ          : stored key and occupied flag
//   gt                : stored key is strictly greater than new_val
module sort_slot
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_new,
    input  logic              take_low,
    input  logic [DATA_W-1:0] new_val,
    input  logic [DATA_W-1:0] low_val,
    input  logic              low_occ,
    output logic [DATA_W-1:0] val,
    output logic              occ,
    output logic              gt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val <= '0;
            occ <= 1'b0;
        end else if (clr) begin
            val <= '0;
            occ <= 1'b0;
        end else if (take_low) begin
            val <= low_val;
            occ <= low_occ;
        end else if (load_new) begin
            val <= new_val;
            occ <= 1'b1;
        end
    end

    // Strict compare: an equal key lands after existing ones, keeping arrival order.
    assign gt = (val > new_val);

endmodule

// File: rtl/fifo_sort_engine.sv
// Drains up to DEPTH words from a FIFO into an ascending insertion-sorted
// register buffer, then streams the sorted words out with valid/ready.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start          : one-cycle run request, honoured only in IDLE
//   fifo_empty     : upstream FIFO empty flag
//   fifo_rd_en     : FIFO pop request (combinational)
//   fifo_rdata     : FIFO data, valid the cycle after fifo_rd_en
//   out_valid/out_ready/out_data/out_last : sorted output stream
//   busy           : high whenever the FSM is not IDLE
//   done           : one-cycle pulse at the end of a run
//   count          : elements captured in the current or last run
//   fsm_state      : current FSM state (debug visibility)
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold their values.
module fifo_sort_engine
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W,
    parameter int DEPTH  = SORT_DEPTH,
    parameter int CNT_W  = SORT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic [1:0]        fsm_state
);

    localparam int IDX_W = $clog2(DEPTH);

    sort_state_e state_q, state_d;
    logic              pend;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    logic [DATA_W-1:0] slot_val [DEPTH];
    logic [DEPTH-1:0]  slot_occ;
    logic [DEPTH-1:0]  slot_gt;
    logic [DEPTH-1:0]  after_pos;
    logic [DEPTH-1:0]  slot_load;
    logic [DEPTH-1:0]  slot_take;

    logic              clr;
    logic              do_insert;
    logic              fill_exit;
    logic              beat;
    logic [CNT_W:0]    used;

    assign clr       = (state_q == IDLE) && start;
    assign do_insert = (state_q == FILL) && pend;
    assign beat      = out_valid && out_ready;
    assign idx_nxt   = idx + IDX_W'(1);

    // Room check counts the word already in flight so the buffer never overflows.
    assign used       = {1'b0, count} + (CNT_W+1)'(pend);
    assign fifo_rd_en = (state_q == FILL) && !fifo_empty && (used < (CNT_W+1)'(DEPTH));
    assign fill_exit  = !fifo_rd_en && !pend;
    assign fsm_state  = state_q;

    // Occupied entries are contiguous and ascending, so after_pos is a
    // thermometer code; its lowest set bit is the insert position and every
    // set bit above it shifts up by one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign after_pos[i] = !slot_occ[i] || slot_gt[i];

        if (i == 0) begin : g_first
            assign slot_load[i] = do_insert && after_pos[i];
            assign slot_take[i] = 1'b0;

            sort_slot #(.DATA_W(DATA_W)) u_slot (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr),
                .load_new (slot_load[i]),
                .take_low (slot_take[i]),
                .new_val  (fifo_rdata),
                .low_val  ('0),
                .low_occ  (1'b0),
                .val      (slot_val[i]),
                .occ      (slot_occ[i]),
                .gt       (slot_gt[i])
            );
        end else begin : g_rest
            assign slot_load[i] = do_insert && after_pos[i] && !after_pos[i-1];
            assign slot_take[i] = do_insert && after_pos[i-1];

            sort_slot #(.DATA_W(DATA_W)) u_slot (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr),
                .load_new (slot_load[i]),
                .take_low (slot_take[i]),
                .new_val  (fifo_rdata),
                .low_val  (slot_val[i-1]),
                .low_occ  (slot_occ[i-1]),
                .val      (slot_val[i]),
                .occ      (slot_occ[i]),
                .gt       (slot_gt[i])
            );
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = FILL;
            FILL: if (fill_exit) state_d = (count != '0) ? EMIT : DONE;
            EMIT: if (beat && out_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend      <= 1'b0;
            count     <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            pend <= fifo_rd_en;
            busy <= (state_d != IDLE);
            // Pulse lands one cycle after the DONE state.
            done <= (state_q == DONE);

            if (clr) begin
                count <= '0;
            end else if (do_insert) begin
                count <= count + CNT_W'(1);
            end

            if (state_q == FILL && state_d == EMIT) begin
                idx       <= '0;
                out_valid <= 1'b1;
                out_data  <= slot_val[0];
                out_last  <= (count == CNT_W'(1));
            end else if (state_q == EMIT && beat) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    idx      <= idx_nxt;
                    out_data <= slot_val[idx_nxt];
                    // idx_nxt == count-1, rearranged to avoid unsigned underflow.
                    out_last <= ((CNT_W'(idx) + CNT_W'(2)) == count);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_sort_engine.sv
// Directed bench for fifo_sort_engine with a behavioural FIFO, an expected
// output queue and a negedge monitor that compares every output beat.
module tb_fifo_sort_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rdata = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [7:0] count;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    fifo_sort_engine #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .fsm_state  (fsm_state)
    );

    // ---------------- FIFO model (not affected by DUT reset) ----------------
    logic [7:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= fifo_mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    int total = 0;
    int bad   = 0;
    int t0 = 0;
    int first_valid = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int pops = 0;
    int beats = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (fifo_rd_en) begin
                pops++;
                if (fifo_empty) begin
                    total++;
                    bad++;
                    $display("FAIL pop_on_empty: rd_en=1 while fifo_empty=1 at cycle %0d", cyc - t0);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc - t0;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc - t0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data=%02h last=%0b, expected no output", out_data, out_last);
                end else if (out_ready) begin
                    exp_e = exp_q.pop_front();
                    beats++;
                    total++;
                    if ({out_last, out_data} !== exp_e) begin
                        bad++;
                        $display("FAIL beat: got data=%02h last=%0b, expected data=%02h last=%0b",
                                 out_data, out_last, exp_e[7:0], exp_e[8]);
                    end
                end else begin
                    total++;
                    if (out_data !== exp_q[0][7:0]) begin
                        bad++;
                        $display("FAIL stall_hold: got data=%02h, expected %02h", out_data, exp_q[0][7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_out(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    // Start is sampled at "edge 0"; t0 is set so cycle k after it reads as k.
    task automatic run_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        first_valid = -1;
        done_cyc = -1;
        done_cnt = 0;
        pops = 0;
        beats = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (done_cyc >= 0) break;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},    int'(fifo_rd_en), 0);
        check({tag, "_valid"},    int'(out_valid), 0);
        check({tag, "_last"},     int'(out_last), 0);
        check({tag, "_busy"},     int'(busy), 0);
        check({tag, "_done"},     int'(done), 0);
        check({tag, "_data"},     int'(out_data), 0);
        check({tag, "_count"},    int'(count), 0);
        check({tag, "_state"},    int'(fsm_state), 0);
    endtask

    int ready_pat [4] = '{1, 0, 0, 1};

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // ---------------- basic sort ----------------
        push(8'h05); push(8'hA5); push(8'h00); push(8'h3C);
        expect_out(8'h00, 0); expect_out(8'h05, 0); expect_out(8'h3C, 0); expect_out(8'hA5, 1);
        run_start();
        #1;
        check("basic_busy_during_fill", int'(busy), 1);
        wait_done(100);
        check("basic_first_valid", first_valid, 7);
        check("basic_done_cycle", done_cyc, 12);
        check("basic_done_width", done_cnt, 1);
        check("basic_count", int'(count), 4);
        check("basic_pops", pops, 4);
        check("basic_beats", beats, 4);
        check("basic_busy_after", int'(busy), 0);
        check("basic_exp_left", exp_q.size(), 0);

        // ---------------- equal keys ----------------
        push(8'hA5); push(8'hA5); push(8'h01);
        expect_out(8'h01, 0); expect_out(8'hA5, 0); expect_out(8'hA5, 1);
        run_start();
        wait_done(100);
        check("dup_count", int'(count), 3);
        check("dup_first_valid", first_valid, 6);
        check("dup_beats", beats, 3);

        // ---------------- overflow: 20 words, 16 taken ----------------
        push(8'h50); push(8'h10); push(8'hF0); push(8'h33);
        push(8'h10); push(8'h80); push(8'h01); push(8'h7F);
        push(8'hC0); push(8'h22); push(8'h99); push(8'h05);
        push(8'hAA); push(8'h60); push(8'h3C); push(8'hFF);
        push(8'h44); push(8'h02); push(8'hE0); push(8'h11);
        expect_out(8'h01, 0); expect_out(8'h05, 0); expect_out(8'h10, 0); expect_out(8'h10, 0);
        expect_out(8'h22, 0); expect_out(8'h33, 0); expect_out(8'h3C, 0); expect_out(8'h50, 0);
        expect_out(8'h60, 0); expect_out(8'h7F, 0); expect_out(8'h80, 0); expect_out(8'h99, 0);
        expect_out(8'hAA, 0); expect_out(8'hC0, 0); expect_out(8'hF0, 0); expect_out(8'hFF, 1);
        run_start();
        wait_done(200);
        check("ovf_pops", pops, 16);
        check("ovf_count", int'(count), 16);
        check("ovf_first_valid", first_valid, 19);
        check("ovf_done_cycle", done_cyc, 36);
        check("ovf_fifo_left", wr_ptr - rd_ptr, 4);
        check("ovf_beats", beats, 16);

        expect_out(8'h02, 0); expect_out(8'h11, 0); expect_out(8'h44, 0); expect_out(8'hE0, 1);
        run_start();
        wait_done(100);
        check("ovf2_count", int'(count), 4);
        check("ovf2_pops", pops, 4);
        check("ovf2_fifo_left", wr_ptr - rd_ptr, 0);

        // ---------------- empty FIFO ----------------
        run_start();
        wait_done(50);
        check("empty_pops", pops, 0);
        check("empty_done_cycle", done_cyc, 3);
        check("empty_first_valid", first_valid, -1);
        check("empty_count", int'(count), 0);
        check("empty_done_width", done_cnt, 1);

        // ---------------- backpressure ----------------
        push(8'h09); push(8'h03); push(8'h07);
        expect_out(8'h03, 0); expect_out(8'h07, 0); expect_out(8'h09, 1);
        run_start();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            out_ready = ready_pat[k % 4][0];
            if (done_cyc >= 0) break;
        end
        out_ready = 1'b1;
        wait_done(50);
        check("stall_beats", beats, 3);
        check("stall_exp_left", exp_q.size(), 0);
        check("stall_count", int'(count), 3);

        // ---------------- reset during FILL ----------------
        push(8'h40); push(8'h30); push(8'h20); push(8'h10); push(8'h08); push(8'h04);
        run_start();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_pops_before", pops, 2);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_fifo_left", wr_ptr - rd_ptr, 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_out(8'h04, 0); expect_out(8'h08, 0); expect_out(8'h10, 0); expect_out(8'h20, 1);
        run_start();
        wait_done(100);
        check("midrst_count", int'(count), 4);
        check("midrst_first_valid", first_valid, 7);
        check("midrst_beats", beats, 4);
        check("midrst_exp_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
